// File: rtl/packet_link_arbiter.sv
// Round-robin arbiter sharing one serial packet link between N_REQ packetizers.
// Grants are held while the owner's lock is high; acks are steered back by ID.
module packet_link_arbiter #(
  parameter int N_REQ        = 4,
  parameter int ID_BITS      = 3,
  parameter int PACKET_WIDTH = 16,
  parameter int MAX_BEATS    = 64
) (
  input  logic                            clk_packet,
  input  logic                            reset,
  input  logic [N_REQ-1:0]                req_i,
  input  logic [N_REQ-1:0]                lock_i,
  input  logic [N_REQ*PACKET_WIDTH-1:0]   packet_i,
  output logic [N_REQ-1:0]                grant_o,
  output logic [PACKET_WIDTH-1:0]         packet_o,
  output logic                            packet_valid_o,
  output logic [ID_BITS-1:0]              owner_o,
  input  logic                            received_i,
  input  logic [ID_BITS-1:0]              received_id_i,
  output logic [N_REQ-1:0]                received_o,
  output logic                            error_o
);

  localparam int BEAT_W = $clog2(MAX_BEATS);

  typedef enum logic [1:0] {IDLE, BUSY, TAIL} state_t;

  state_t              state_q, state_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic [ID_BITS-1:0]  owner_q, owner_d;
  logic [ID_BITS-1:0]  ptr_q, ptr_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [N_REQ-1:0]    received_q, received_d;
  logic                error_q, error_d;

  logic                win_found;
  logic [ID_BITS-1:0]  win_idx;
  logic [ID_BITS-1:0]  ptr_next;
  logic [N_REQ-1:0]    win_onehot;
  logic                lock_owner;
  logic                link_active;

  // Search starts at ptr and wraps, so the last winner has lowest priority.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!win_found && req_i[(int'(ptr_q) + i) % N_REQ]) begin
        win_found = 1'b1;
        win_idx   = ID_BITS'((int'(ptr_q) + i) % N_REQ);
      end
    end
    ptr_next = ID_BITS'((int'(win_idx) + 1) % N_REQ);
    for (int k = 0; k < N_REQ; k++) begin
      win_onehot[k] = (int'(win_idx) == k);
    end
  end

  always_comb begin
    lock_owner = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (int'(owner_q) == k) lock_owner = lock_i[k];
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    beat_d  = beat_q;
    error_d = error_q;
    case (state_q)
      IDLE, TAIL: begin
        // TAIL re-arbitrates immediately so back-to-back packets have no gap.
        state_d = IDLE;
        grant_d = '0;
        if (win_found) begin
          state_d = BUSY;
          grant_d = win_onehot;
          owner_d = win_idx;
          ptr_d   = ptr_next;
          beat_d  = '0;
        end
      end
      BUSY: begin
        if (!lock_owner) begin
          state_d = TAIL;
          grant_d = '0;
        end else if (beat_q == BEAT_W'(MAX_BEATS - 1)) begin
          state_d = TAIL;
          grant_d = '0;
          error_d = 1'b1;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Ack IDs at or above N_REQ match no bit and are dropped.
  always_comb begin
    for (int k = 0; k < N_REQ; k++) begin
      received_d[k] = received_i && (int'(received_id_i) == k);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_packet or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      owner_q    <= '0;
      ptr_q      <= '0;
      beat_q     <= '0;
      received_q <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      beat_q     <= beat_d;
      received_q <= received_d;
      error_q    <= error_d;
    end
  end

  assign link_active = (state_q == BUSY) || (state_q == TAIL);

  always_comb begin
    packet_o = '0;
    if (link_active) begin
      for (int k = 0; k < N_REQ; k++) begin
        if (int'(owner_q) == k) packet_o = packet_i[k*PACKET_WIDTH +: PACKET_WIDTH];
      end
    end
  end

  assign packet_valid_o = link_active;
  assign grant_o        = grant_q;
  assign owner_o        = owner_q;
  assign received_o     = received_q;
  assign error_o        = error_q;

endmodule
